// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 streaming window generator: border modes,
// controller states and tap slice positions within the packed window.
package window_pkg;

    localparam int BORDER_ZERO = 0;
    localparam int BORDER_REPL = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Tap k occupies win[(Pk)*DATA_W +: DATA_W]; P1 is top-left, P9 bottom-right.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P5 = 4;
    localparam int P6 = 5;
    localparam int P7 = 6;
    localparam int P8 = 7;
    localparam int P9 = 8;

endpackage

// File: rtl/window3x3_stream_line_buffer.sv
// Circular line buffer: each enabled push stores din_i and presents the sample
// that was pushed DEPTH pushes before the next one, so dout_o lines up with it.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q;
    logic [AW-1:0]     ptr_d;
    logic [DATA_W-1:0] dout_q;

    always_comb begin
        ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    // Prefetch the slot the next push will overwrite; RAM contents are never cleared.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
            dout_q       <= mem_q[ptr_d];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/window3x3_stream.sv
// Raster-order pixel stream in, one bordered 3x3 window per pixel out,
// using two cascaded line buffers instead of a frame store.
//
// state | meaning
// FILL  | accept first IMG_W+1 pixels of a frame, no windows yet
// RUN   | each accepted pixel completes and loads one window
// FLUSH | input closed, emit the last IMG_W+1 windows with bottom border
module window3x3_stream
    import window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int BORDER = BORDER_ZERO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   pixel_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] win,
    output logic                out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    generate
        if (IMG_W < 3) begin : g_bad_width
            $error("window3x3_stream: IMG_W must be >= 3");
        end
        if (IMG_H < 2) begin : g_bad_height
            $error("window3x3_stream: IMG_H must be >= 2");
        end
        if (BORDER != BORDER_ZERO && BORDER != BORDER_REPL) begin : g_bad_border
            $error("window3x3_stream: BORDER must be 0 or 1");
        end
    endgenerate

    state_e                          state_q, state_d;
    logic [CW-1:0]                   in_col_q, in_col_d, o_col_q, o_col_d;
    logic [RW-1:0]                   in_row_q, in_row_d, o_row_q, o_row_d;
    logic [0:2][0:2][DATA_W-1:0]     raw_q, raw_d;
    logic [9*DATA_W-1:0]             win_q, win_d, asm_win;
    logic                            out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                            slot_free, in_ready_c, accept, load, advance;
    logic                            in_last, o_last;
    logic [DATA_W-1:0]               lb0_dout, lb1_dout;

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .rst(rst), .en_i(advance), .din_i(pixel_in), .dout_o(lb0_dout)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .rst(rst), .en_i(advance), .din_i(lb0_dout), .dout_o(lb1_dout)
    );

    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        o_col_d     = o_col_q;
        o_row_d     = o_row_q;
        raw_d       = raw_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        slot_free = !out_valid_q || out_ready;
        unique case (state_q)
            FILL:    in_ready_c = 1'b1;
            RUN:     in_ready_c = slot_free;
            default: in_ready_c = 1'b0;
        endcase
        accept  = in_valid && in_ready_c;
        load    = (state_q == RUN && accept) || (state_q == FLUSH && slot_free);
        advance = accept || load;
        in_last = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
        o_last  = (o_row_q == ROW_MAX) && (o_col_q == COL_MAX);

        if (accept) begin
            in_col_d = (in_col_q == COL_MAX) ? '0 : in_col_q + CW'(1);
            if (in_col_q == COL_MAX) begin
                in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + RW'(1);
            end
        end

        // New right-hand column: rows r-2, r-1, r relative to the input pixel.
        if (advance) begin
            for (int r = 0; r < 3; r++) begin
                raw_d[r][0] = raw_q[r][1];
                raw_d[r][1] = raw_q[r][2];
            end
            raw_d[0][2] = lb1_dout;
            raw_d[1][2] = lb0_dout;
            raw_d[2][2] = pixel_in;
        end

        if (load) begin
            win_d       = asm_win;
            out_last_d  = o_last;
            out_valid_d = 1'b1;
            o_col_d     = (o_col_q == COL_MAX) ? '0 : o_col_q + CW'(1);
            if (o_col_q == COL_MAX) begin
                o_row_d = (o_row_q == ROW_MAX) ? '0 : o_row_q + RW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // FLUSH ends once the final window is loaded, so a new frame can start
        // filling while that window is still waiting for downstream.
        unique case (state_q)
            FILL:    if (accept && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
            RUN:     if (accept && in_last) state_d = FLUSH;
            FLUSH:   if (load && o_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outside taps fold onto the centre row/column: zeroed or replicated.
    always_comb begin
        logic row_out, col_out;
        int   sr, sc;
        asm_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                row_out = (r == 0 && o_row_q == '0) || (r == 2 && o_row_q == ROW_MAX);
                col_out = (c == 0 && o_col_q == '0) || (c == 2 && o_col_q == COL_MAX);
                sr = row_out ? 1 : r;
                sc = col_out ? 1 : c;
                if (BORDER == BORDER_ZERO && (row_out || col_out)) begin
                    asm_win[(P1 + r*3 + c)*DATA_W +: DATA_W] = '0;
                end else begin
                    asm_win[(P1 + r*3 + c)*DATA_W +: DATA_W] = raw_d[sr][sc];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            in_col_q    <= '0;
            in_row_q    <= '0;
            o_col_q     <= '0;
            o_row_q     <= '0;
            raw_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            o_col_q     <= o_col_d;
            o_row_q     <= o_row_d;
            raw_q       <= raw_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign win       = win_q;
    assign out_last  = out_last_q;

endmodule
